// File: rtl/err_inj_pkg.sv
// Shared encodings for the error-injection sequencer: command modes and FSM states.
package err_inj_pkg;

  typedef enum logic [1:0] {
    ModePulse    = 2'd0,
    ModeBurst    = 2'd1,
    ModePeriodic = 2'd2,
    ModeSticky   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StDelay  = 2'd1,
    StActive = 2'd2,
    StGap    = 2'd3
  } state_e;

endpackage

// File: rtl/err_tgt_decode.sv
// Combinational target decoder: maps a target index onto a one-hot local error line,
// a forwarded sub-range index, or flags it as bad. Local lines win where ranges overlap.
module err_tgt_decode
  import err_inj_pkg::*;
#(
  parameter int unsigned INW  = 5,
  parameter int unsigned LCL  = 6,
  parameter int unsigned LOW  = 6,
  parameter int unsigned HIGH = 14,
  parameter int unsigned OUTW = 4
) (
  input  logic [INW-1:0]  tgt,
  output logic [LCL-1:0]  lcl_oh,
  output logic            sub_vld,
  output logic [OUTW-1:0] sub_idx,
  output logic            bad
);

  logic [31:0] tgt_ext;
  assign tgt_ext = 32'(tgt);

  // Classify the target: local first, then forwarded sub-range, otherwise bad.
  always_comb begin
    lcl_oh  = '0;
    sub_vld = 1'b0;
    sub_idx = '0;
    bad     = 1'b0;
    if (tgt_ext < LCL) begin
      lcl_oh = {{(LCL-1){1'b0}}, 1'b1} << tgt_ext;
    end else if (tgt_ext >= LOW && tgt_ext <= HIGH) begin
      sub_vld = 1'b1;
      sub_idx = OUTW'(tgt_ext - LOW);
    end else begin
      bad = 1'b1;
    end
  end

endmodule

// File: rtl/err_inj_sequencer.sv
// Error-injection sequencer: accepts one command at a time and drives a local one-hot
// error line or a forwarded sub-range error for PULSE/BURST/PERIODIC/STICKY timing.
// Optional feature: define ERR_INJ_STATS_EN to count accepted in-range commands.
module err_inj_sequencer
  import err_inj_pkg::*;
#(
  parameter int unsigned INW  = 5,
  parameter int unsigned LCL  = 6,
  parameter int unsigned LOW  = 6,
  parameter int unsigned HIGH = 14,
  parameter int unsigned OUTW = 4,
  parameter int unsigned DURW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            err_en,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [INW-1:0]  cmd_tgt,
  input  logic [1:0]      cmd_mode,
  input  logic [DURW-1:0] cmd_dur,
  input  logic [DURW-1:0] cmd_dly,
  input  logic            cancel,
  output logic [LCL-1:0]  lcl_err,
  output logic            sub_err_en,
  output logic [OUTW-1:0] sub_err_ctrl,
  output logic            busy,
  output logic            done,
  output logic            cmd_bad,
  output logic [15:0]     inj_count
);

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [DURW-1:0]   cnt_q, cnt_d;
  logic [DURW-1:0]   dur_q, dur_d;
  logic [LCL-1:0]    lcl_q, lcl_d;
  logic              sub_vld_q, sub_vld_d;
  logic [OUTW-1:0]   sub_idx_q, sub_idx_d;
  logic              done_q, done_d;
  logic              bad_q, bad_d;

  logic [LCL-1:0]    dec_lcl;
  logic              dec_sub_vld;
  logic [OUTW-1:0]   dec_sub_idx;
  logic              dec_bad;
  logic              accept;
  logic              act_vis;

  err_tgt_decode #(
    .INW  (INW),
    .LCL  (LCL),
    .LOW  (LOW),
    .HIGH (HIGH),
    .OUTW (OUTW)
  ) u_decode (
    .tgt     (cmd_tgt),
    .lcl_oh  (dec_lcl),
    .sub_vld (dec_sub_vld),
    .sub_idx (dec_sub_idx),
    .bad     (dec_bad)
  );

  // A zero duration means one cycle.
  function automatic logic [DURW-1:0] eff_dur(input logic [DURW-1:0] d);
    return (d == '0) ? DURW'(1) : d;
  endfunction

  // Counter preload on entering ACTIVE; only BURST counts down inside ACTIVE.
  function automatic logic [DURW-1:0] active_load(input mode_e m, input logic [DURW-1:0] d);
    return (m == ModeBurst) ? eff_dur(d) : '0;
  endfunction

  assign cmd_ready = (state_q == StIdle) && err_en;
  assign accept    = cmd_valid && cmd_ready;

  // Next-state, counter and command-capture logic; everything holds while err_en is low.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    dur_d     = dur_q;
    lcl_d     = lcl_q;
    sub_vld_d = sub_vld_q;
    sub_idx_d = sub_idx_q;
    done_d    = 1'b0;
    bad_d     = 1'b0;
    if (err_en) begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (dec_bad) begin
              bad_d = 1'b1;
            end else begin
              lcl_d     = dec_lcl;
              sub_vld_d = dec_sub_vld;
              sub_idx_d = dec_sub_idx;
              mode_d    = mode_e'(cmd_mode);
              dur_d     = cmd_dur;
              if (cmd_dly != '0) begin
                state_d = StDelay;
                cnt_d   = cmd_dly;
              end else begin
                state_d = StActive;
                cnt_d   = active_load(mode_e'(cmd_mode), cmd_dur);
              end
            end
          end
        end
        StDelay: begin
          if (cancel) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else if (cnt_q <= DURW'(1)) begin
            state_d = StActive;
            cnt_d   = active_load(mode_q, dur_q);
          end else begin
            cnt_d = cnt_q - DURW'(1);
          end
        end
        StActive: begin
          if (cancel) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            unique case (mode_q)
              ModePulse: begin
                state_d = StIdle;
                cnt_d   = '0;
              end
              ModeBurst: begin
                if (cnt_q <= DURW'(1)) begin
                  state_d = StIdle;
                  cnt_d   = '0;
                end else begin
                  cnt_d = cnt_q - DURW'(1);
                end
              end
              ModePeriodic: begin
                state_d = StGap;
                cnt_d   = eff_dur(dur_q);
              end
              ModeSticky: begin
                state_d = StActive;
              end
            endcase
          end
        end
        StGap: begin
          if (cancel) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else if (cnt_q <= DURW'(1)) begin
            state_d = StActive;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - DURW'(1);
          end
        end
      endcase
      done_d = (state_q != StIdle) && (state_d == StIdle);
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      mode_q    <= ModePulse;
      cnt_q     <= '0;
      dur_q     <= '0;
      lcl_q     <= '0;
      sub_vld_q <= 1'b0;
      sub_idx_q <= '0;
      done_q    <= 1'b0;
      bad_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
      dur_q     <= dur_d;
      lcl_q     <= lcl_d;
      sub_vld_q <= sub_vld_d;
      sub_idx_q <= sub_idx_d;
      done_q    <= done_d;
      bad_q     <= bad_d;
    end
  end

  // err_en gates the registered target combinationally so masking takes effect in the same cycle.
  assign act_vis      = (state_q == StActive) && err_en;
  assign lcl_err      = act_vis ? lcl_q : '0;
  assign sub_err_en   = act_vis && sub_vld_q;
  assign sub_err_ctrl = (act_vis && sub_vld_q) ? sub_idx_q : '0;
  assign busy         = (state_q != StIdle);
  assign done         = done_q;
  assign cmd_bad      = bad_q;

`ifdef ERR_INJ_STATS_EN
  logic [15:0] inj_cnt_q, inj_cnt_d;

  // Saturating count of accepted in-range commands.
  always_comb begin
    inj_cnt_d = inj_cnt_q;
    if (accept && !dec_bad && inj_cnt_q != 16'hFFFF) begin
      inj_cnt_d = inj_cnt_q + 16'd1;
    end
  end

  // Statistics register.
  always_ff @(posedge clk) begin
    if (rst) begin
      inj_cnt_q <= '0;
    end else begin
      inj_cnt_q <= inj_cnt_d;
    end
  end

  assign inj_count = inj_cnt_q;
`else
  assign inj_count = '0;
`endif

endmodule

// File: tb/tb_err_inj_sequencer.sv
// Bench for err_inj_sequencer: directed scenarios plus randomized commands checked against
// a cycle-offset arithmetic model of each command's timeline.
module tb_err_inj_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       err_en;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [4:0] cmd_tgt;
  logic [1:0] cmd_mode;
  logic [7:0] cmd_dur;
  logic [7:0] cmd_dly;
  logic       cancel;
  logic [5:0] lcl_err;
  logic       sub_err_en;
  logic [3:0] sub_err_ctrl;
  logic       busy;
  logic       done;
  logic       cmd_bad;
  logic [15:0] inj_count;

  int vectors     = 0;
  int miscompares = 0;
  int exp_inj     = 0;

  err_inj_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .err_en       (err_en),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_tgt      (cmd_tgt),
    .cmd_mode     (cmd_mode),
    .cmd_dur      (cmd_dur),
    .cmd_dly      (cmd_dly),
    .cancel       (cancel),
    .lcl_err      (lcl_err),
    .sub_err_en   (sub_err_en),
    .sub_err_ctrl (sub_err_ctrl),
    .busy         (busy),
    .done         (done),
    .cmd_bad      (cmd_bad),
    .inj_count    (inj_count)
  );

  always #5 clk = ~clk;

  // Issue one command and check every cycle until one cycle past its expected end.
  // canc = cycle offset (after accept) during which cancel is held; 0 = never.
  task automatic run_cmd(input int tgt, input int mode, input int dur, input int dly,
                         input int canc);
    int s, d, nat_e, e;
    bit bad, loc, act;
    logic [14:0] obs, expv;
    logic [5:0] el;
    logic [3:0] ectl;
    bad = (tgt > 14);
    loc = (tgt < 6);
    d = (dur == 0) ? 1 : dur;
    s = 1 + dly;
    case (mode)
      0:       nat_e = s + 1;
      1:       nat_e = s + d;
      default: nat_e = 100000;
    endcase
    e = (canc != 0 && canc < nat_e) ? canc + 1 : nat_e;
    if (bad) e = 1;
`ifdef ERR_INJ_STATS_EN
    if (!bad && exp_inj < 65535) exp_inj++;
`endif
    cmd_tgt   = 5'(tgt);
    cmd_mode  = 2'(mode);
    cmd_dur   = 8'(dur);
    cmd_dly   = 8'(dly);
    cmd_valid = 1'b1;
    @(negedge clk);
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_before_cmd tgt=%0d: got %b want 1", tgt, cmd_ready);
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int k = 1; k <= e + 1; k++) begin
      if (!bad && canc == k && canc < nat_e) cancel = 1'b1;
      act = !bad && k >= s && k < e && (mode != 2 || ((k - s) % (d + 1)) == 0);
      el   = (act && loc) ? 6'(1 << tgt) : 6'b0;
      ectl = (act && !loc) ? 4'(tgt - 6) : 4'b0;
      expv = {el, act && !loc, ectl, !bad && k < e, !bad && k == e, bad && k == 1,
              bad || k >= e};
      @(negedge clk);
      obs = {lcl_err, sub_err_en, sub_err_ctrl, busy, done, cmd_bad, cmd_ready};
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL cycle tgt=%0d mode=%0d dur=%0d dly=%0d canc=%0d k=%0d: {lcl,sub_en,ctrl,busy,done,bad,ready} got %b want %b",
                 tgt, mode, dur, dly, canc, k, obs, expv);
      end
      if (k == 1) begin
        vectors++;
        if (inj_count !== 16'(exp_inj)) begin
          miscompares++;
          $display("FAIL inj_count tgt=%0d: got %0d want %0d", tgt, inj_count, exp_inj);
        end
      end
      @(posedge clk);
      #1 cancel = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_inj = 0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    vectors++;
    if ({lcl_err, sub_err_en, sub_err_ctrl, busy, done, cmd_bad, inj_count} !== 30'b0 ||
        cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_state: lcl=%b sub=%b ctrl=%0d busy=%b done=%b bad=%b cnt=%0d ready=%b want all 0, ready 1",
               lcl_err, sub_err_en, sub_err_ctrl, busy, done, cmd_bad, inj_count, cmd_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    run_cmd(3, 0, 0, 0, 0);   // PULSE local
    run_cmd(9, 1, 4, 2, 0);   // BURST forwarded with delay
    run_cmd(0, 2, 2, 0, 6);   // PERIODIC, cancel in gap
    run_cmd(20, 0, 0, 0, 0);  // out of range
    run_cmd(14, 1, 0, 0, 0);  // upper sub boundary, dur 0 -> 1
    run_cmd(6, 3, 0, 1, 4);   // lower sub boundary, STICKY cancelled
    run_cmd(5, 0, 0, 3, 2);   // cancel during delay
  endtask

  // BURST with err_en dropped mid-burst: counters must freeze, not run down.
  task automatic test_freeze();
    bit en, ea;
    cmd_tgt = 5'd2; cmd_mode = 2'd1; cmd_dur = 8'd3; cmd_dly = 8'd1; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      en = !(k == 3 || k == 4);
      err_en = en;
      ea = (k == 2 || k == 5 || k == 6);
      @(negedge clk);
      vectors++;
      if (lcl_err !== (ea ? 6'b000100 : 6'b0) || done !== (k == 7)) begin
        miscompares++;
        $display("FAIL freeze_burst k=%0d: lcl=%b done=%b want lcl=%b done=%b",
                 k, lcl_err, done, ea ? 6'b000100 : 6'b0, k == 7);
      end
      @(posedge clk);
      #1;
    end
    err_en = 1'b1;
`ifdef ERR_INJ_STATS_EN
    exp_inj++;
`endif
  endtask

  // STICKY masked by err_en, then reset mid-injection.
  task automatic test_sticky_reset();
    cmd_tgt = 5'd5; cmd_mode = 2'd3; cmd_dur = 8'd0; cmd_dly = 8'd0; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      err_en = !(k >= 3 && k <= 5);
      @(negedge clk);
      vectors++;
      if (lcl_err !== (err_en ? 6'b100000 : 6'b0)) begin
        miscompares++;
        $display("FAIL sticky_mask k=%0d: lcl=%b want %b", k, lcl_err,
                 err_en ? 6'b100000 : 6'b0);
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_inj = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      vectors++;
      if ({lcl_err, sub_err_en, sub_err_ctrl, busy, done, cmd_bad, inj_count} !== 30'b0) begin
        miscompares++;
        $display("FAIL reset_mid_inject k=%0d: lcl=%b sub=%b busy=%b done=%b cnt=%0d want 0",
                 k, lcl_err, sub_err_en, busy, done, inj_count);
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Cancel alongside a new command in IDLE must not block acceptance.
  task automatic test_cancel_idle();
    cmd_tgt = 5'd1; cmd_mode = 2'd0; cmd_dur = 8'd0; cmd_dly = 8'd0;
    cmd_valid = 1'b1; cancel = 1'b1;
    @(posedge clk);
    #1 begin cmd_valid = 1'b0; cancel = 1'b0; end
`ifdef ERR_INJ_STATS_EN
    exp_inj++;
`endif
    @(negedge clk);
    vectors++;
    if (lcl_err !== 6'b000010 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL cancel_idle: lcl=%b busy=%b want 000010 1", lcl_err, busy);
    end
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (done !== 1'b1 || lcl_err !== 6'b0) begin
      miscompares++;
      $display("FAIL cancel_idle_done: done=%b lcl=%b want 1 000000", done, lcl_err);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    int mode, c;
    for (int n = 0; n < 30; n++) begin
      mode = int'($urandom_range(0, 3));
      c = (mode >= 2) ? int'($urandom_range(1, 12)) : int'($urandom_range(0, 6));
      run_cmd(int'($urandom_range(0, 22)), mode, int'($urandom_range(0, 4)),
              int'($urandom_range(0, 3)), c);
    end
  endtask

  task automatic test_stats();
    do_reset();
    run_cmd(2, 0, 0, 0, 0);
    run_cmd(11, 1, 2, 0, 0);
    run_cmd(25, 0, 0, 0, 0);
    run_cmd(4, 0, 0, 1, 0);
    @(negedge clk);
    vectors++;
`ifdef ERR_INJ_STATS_EN
    if (inj_count !== 16'd3) begin
      miscompares++;
      $display("FAIL stats_total: got %0d want 3", inj_count);
    end
`else
    if (inj_count !== 16'd0) begin
      miscompares++;
      $display("FAIL stats_total: got %0d want 0", inj_count);
    end
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; err_en = 1'b1; cmd_valid = 1'b0; cancel = 1'b0;
    cmd_tgt = '0; cmd_mode = '0; cmd_dur = '0; cmd_dly = '0;
    test_reset();
    test_directed();
    test_freeze();
    test_cancel_idle();
    test_sticky_reset();
    test_random();
    test_stats();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/err_inj_sequencer.md
ERR_INJ_SEQUENCER -- requirements
Module: err_inj_sequencer

Interface
REQ-001 SHALL have parameter INW, default 5: target index width.
REQ-002 SHALL have parameter LCL, default 6: local error line count; local targets 0..LCL-1.
REQ-003 SHALL have parameters LOW=6, HIGH=14, OUTW=4: forwarded sub-range [LOW,HIGH], sub index width.
REQ-004 SHALL have parameter DURW, default 8: duration/delay counter width.
REQ-005 SHALL have port clk, input, 1: the only clock.
REQ-006 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port err_en, input, 1: global enable; low masks outputs and freezes counters.
REQ-008 SHALL have ports cmd_valid (input, 1) and cmd_ready (output, 1): command handshake.
REQ-009 SHALL have ports cmd_tgt (input, INW), cmd_mode (input, 2), cmd_dur (input, DURW), cmd_dly (input, DURW): command fields.
REQ-010 SHALL have port cancel, input, 1: abort the current injection.
REQ-011 SHALL have port lcl_err, output, LCL: registered one-hot local error lines.
REQ-012 SHALL have ports sub_err_en (output, 1) and sub_err_ctrl (output, OUTW): registered forwarded error, index = tgt-LOW.
REQ-013 SHALL have ports busy (output, 1), done (output, 1), cmd_bad (output, 1), inj_count (output, 16).

Function
REQ-014 SHALL accept a command on a clk edge with cmd_valid && cmd_ready; cmd_ready = (state==IDLE) && err_en.
REQ-015 SHALL implement states IDLE, DELAY, ACTIVE, GAP; busy high in any state except IDLE.
REQ-016 SHALL on accept go to DELAY if cmd_dly!=0 (stay cmd_dly cycles), else ACTIVE; first ACTIVE cycle = accept+1+cmd_dly.
REQ-017 SHALL drive decoded outputs exactly during ACTIVE cycles with err_en high; all outputs 0 otherwise.
REQ-018 SHALL implement mode 0 PULSE: one ACTIVE cycle, then IDLE.
REQ-019 SHALL implement mode 1 BURST: cmd_dur ACTIVE cycles (0 treated as 1), then IDLE.
REQ-020 SHALL implement mode 2 PERIODIC: 1 ACTIVE cycle, cmd_dur GAP cycles (0 treated as 1), repeated until cancel.
REQ-021 SHALL implement mode 3 STICKY: ACTIVE until cancel.
REQ-022 SHALL pulse done for one cycle in the first IDLE cycle after any non-IDLE state.
REQ-023 SHALL on cancel in a non-IDLE state enter IDLE next edge with outputs 0; cancel in IDLE is ignored; cancel with cmd_valid in IDLE: command accepted.
REQ-024 SHALL treat tgt outside [0,LCL-1] and [LOW,HIGH] as bad: accept, pulse cmd_bad one cycle, remain IDLE, no done.
REQ-025 SHALL, while err_en low, freeze state and counters and force outputs to 0; resume unchanged when err_en returns.
REQ-026 SHALL leave overlapping local/sub ranges with local priority.

Reset
REQ-027 SHALL on rst: state IDLE, counters 0, lcl_err 0, sub_err_en 0, sub_err_ctrl 0, busy 0, done 0, cmd_bad 0, inj_count 0; reset mid-injection clears outputs at that edge, no done.

Configuration
REQ-028 SHALL with ERR_INJ_STATS_EN defined increment inj_count (saturating at 16'hFFFF) on each accepted in-range command.
REQ-029 SHALL without ERR_INJ_STATS_EN tie inj_count to 0 with no counter logic.

Structure
REQ-030 SHALL place mode encoding (PULSE/BURST/PERIODIC/STICKY) and state encoding in shared package err_inj_pkg.
REQ-031 SHALL use one combinational sub-module err_tgt_decode: tgt -> one-hot lcl, sub valid, sub index, bad flag.

Verification
REQ-032 SHALL cover PULSE tgt=3 dly=0 accepted at T -> lcl_err=6'b001000 at T+1 only, done at T+2.
REQ-033 SHALL cover BURST tgt=9 dur=4 dly=2 at T -> sub_err_en=1, sub_err_ctrl=3 for T+3..T+6, lcl_err=0, done at T+7.
REQ-034 SHALL cover PERIODIC tgt=0 dur=2 -> lcl_err[0] 1,0,0,1,0,0; cancel -> 0 next edge, done pulse, cmd_ready high.
REQ-035 SHALL cover tgt=20 -> cmd_bad one cycle, all outputs 0, busy 0, no done.
REQ-036 SHALL cover STICKY tgt=5 with err_en low 3 cycles -> lcl_err[5] 0 during, 1 after; rst mid-injection -> all 0, inj_count 0.
REQ-037 SHALL cover stats: three in-range and one bad command -> inj_count=3 with ERR_INJ_STATS_EN, 0 without.
